// File: rtl/rx_hdlc_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_hdlc_deframer_if
//  Purpose  : Bundles the line-side inputs and the host-side outputs of the
//             HDLC receive deframer.
//  Modports : master - upstream/host view (drives line inputs, reads status)
//             slave  - deframer view (reads line inputs, drives status)
//  Signals  : bit_en, rxdata, my_addr, promisc                (to deframer)
//             byte_valid, dout, sof, frame_done, frame_good,
//             err_fcs, err_abort, err_short, err_long, err_align,
//             frame_len, idle, rx_active                     (from deframer)
//  Revision : 1.0  initial release
// ============================================================================
interface rx_hdlc_deframer_if #(
  parameter int LEN_WIDTH = 12
);
  logic                 bit_en;
  logic                 rxdata;
  logic [7:0]           my_addr;
  logic                 promisc;
  logic                 byte_valid;
  logic [7:0]           dout;
  logic                 sof;
  logic                 frame_done;
  logic                 frame_good;
  logic                 err_fcs;
  logic                 err_abort;
  logic                 err_short;
  logic                 err_long;
  logic                 err_align;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 idle;
  logic                 rx_active;

  modport master (
    output bit_en, rxdata, my_addr, promisc,
    input  byte_valid, dout, sof, frame_done, frame_good,
    input  err_fcs, err_abort, err_short, err_long, err_align,
    input  frame_len, idle, rx_active
  );

  modport slave (
    input  bit_en, rxdata, my_addr, promisc,
    output byte_valid, dout, sof, frame_done, frame_good,
    output err_fcs, err_abort, err_short, err_long, err_align,
    output frame_len, idle, rx_active
  );
endinterface
`default_nettype wire

// File: rtl/rx_hdlc_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_hdlc_deframer
//  Purpose  : HDLC/Econet receive deframer. Flag/abort detection, zero-bit
//             destuffing, CRC-16/CRC-32 FCS check with FCS stripping, address
//             filter, min/max length checks and per-frame status.
//  Ports    : netclk - network clock
//             reset  - asynchronous, active-low
//             rx_if  - rx_hdlc_deframer_if.slave (line inputs, host outputs)
//  Revision : 1.0  initial release
// ============================================================================
module rx_hdlc_deframer #(
  parameter int FCS_WIDTH   = 16,
  parameter int MIN_BYTES   = 4,
  parameter int MAX_BYTES   = 2048,
  parameter int ADDR_FILTER = 1,
  parameter int LEN_WIDTH   = 12
) (
  input  wire logic          netclk,
  input  wire logic          reset,
  rx_hdlc_deframer_if.slave  rx_if
);

  localparam int C_FCS_BYTES = FCS_WIDTH / 8;
  localparam logic [FCS_WIDTH-1:0] C_POLY =
    (FCS_WIDTH == 32) ? FCS_WIDTH'(32'hEDB88320) : FCS_WIDTH'(32'h00008408);
  localparam logic [FCS_WIDTH-1:0] C_RES =
    (FCS_WIDTH == 32) ? FCS_WIDTH'(32'hDEBB20E3) : FCS_WIDTH'(32'h0000F0B8);
  localparam logic [LEN_WIDTH-1:0] C_FCSB = LEN_WIDTH'(C_FCS_BYTES);
  localparam logic [LEN_WIDTH-1:0] C_MIN  = LEN_WIDTH'(MIN_BYTES);
  localparam logic [LEN_WIDTH-1:0] C_MAX  = LEN_WIDTH'(MAX_BYTES);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  logic [1:0]               r_state, w_state_nx;
  logic [7:0]               r_sr;     // raw line window, newest bit at [7]
  logic [7:0]               r_dv;     // per-window-bit "is a data bit" mark
  logic [3:0]               r_ones;
  logic [FCS_WIDTH-1:0]     r_crc;
  logic [7:0]               r_byte;
  logic [2:0]               r_bitcnt;
  logic [LEN_WIDTH-1:0]     r_cnt;
  logic [8*C_FCS_BYTES-1:0] r_dly;    // oldest byte at [7:0]

  logic                 r_byte_valid, r_sof, r_done;
  logic [7:0]           r_dout;
  logic                 r_good, r_efcs, r_eabort, r_eshort, r_elong, r_ealign;
  logic [LEN_WIDTH-1:0] r_len;

  logic                 w_en, w_rx;
  logic [7:0]           w_sr_nx;
  logic                 w_flag, w_abort, w_flag_nx, w_stuff, w_dbit;
  logic                 w_take, w_start, w_proc;
  logic [FCS_WIDTH-1:0] w_crc_base, w_crc_nx;
  logic [2:0]           w_bitcnt_base;
  logic [LEN_WIDTH-1:0] w_cnt_base, w_len;
  logic [7:0]           w_byte_nx;
  logic                 w_byte_done, w_addr_bad, w_long, w_emit, w_sof;
  logic                 w_close, w_abend, w_done;
  logic                 w_e_align, w_e_short, w_e_fcs, w_good;

  assign w_en    = rx_if.bit_en;
  assign w_rx    = rx_if.rxdata;
  assign w_sr_nx = {w_rx, r_sr[7:1]};

  // Framing decisions are taken on the registered window one bit later, so
  // every bit preceding a flag or abort has already left the window and been
  // processed as data by the time the event is acted upon.
  assign w_flag    = (r_sr == 8'h7E);
  assign w_abort   = &r_sr[7:1];
  assign w_flag_nx = (w_sr_nx == 8'h7E);
  // A 0 after exactly five 1s (a sixth 1 would make it flag/abort).
  assign w_stuff   = !w_rx && (r_sr[7:2] == 6'b111110);
  assign w_dbit    = r_sr[0];

  // Data bit leaving the window on this bit_en cycle.
  assign w_take  = w_en && !w_flag && !w_abort && r_dv[0];
  assign w_start = (r_state == S_SYNC) && w_take;
  assign w_proc  = ((r_state == S_SYNC) || (r_state == S_DATA)) && w_take;

  // The first data bit of a frame starts from cleared counters / preset CRC.
  assign w_crc_base    = w_start ? '1 : r_crc;
  assign w_bitcnt_base = w_start ? 3'd0 : r_bitcnt;
  assign w_cnt_base    = w_start ? '0 : r_cnt;
  assign w_crc_nx      = (w_crc_base >> 1) ^
                         ((w_crc_base[0] ^ w_dbit) ? C_POLY : '0);
  assign w_byte_nx     = {w_dbit, r_byte[7:1]};
  assign w_len         = (r_cnt >= C_FCSB) ? (r_cnt - C_FCSB) : '0;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge netclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    if (w_en) begin
      case (r_state)
        S_HUNT: if (w_flag) w_state_nx = S_SYNC;
        S_SYNC: begin
          if (w_abort)      w_state_nx = S_HUNT;
          else if (w_flag)  w_state_nx = S_SYNC;
          else if (w_take)  w_state_nx = S_DATA;
        end
        S_DATA: begin
          if (w_flag)                      w_state_nx = S_SYNC;
          else if (w_abort)                w_state_nx = S_HUNT;
          else if (w_addr_bad || w_long)   w_state_nx = S_DISC;
        end
        default: begin
          if (w_flag)       w_state_nx = S_SYNC;
          else if (w_abort) w_state_nx = S_HUNT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte_done = w_proc && (w_bitcnt_base == 3'd7);
    w_addr_bad  = w_byte_done && (w_cnt_base == '0) && (ADDR_FILTER != 0) &&
                  !rx_if.promisc && (w_byte_nx != rx_if.my_addr) &&
                  (w_byte_nx != 8'hFF);
    // Completing byte MAX_BYTES+1 kills the frame.
    w_long      = w_byte_done && (w_cnt_base == C_MAX);
    // Byte k leaves the delay line when byte k+FCS_BYTES completes.
    w_emit      = w_byte_done && !w_addr_bad && !w_long && (w_cnt_base >= C_FCSB);
    w_sof       = w_emit && (w_cnt_base == C_FCSB);
    w_close     = w_en && (r_state == S_DATA) && w_flag;
    w_abend     = w_en && (r_state == S_DATA) && w_abort;
    w_e_align   = w_close && (r_bitcnt != 3'd0);
    w_e_short   = w_close && !w_e_align && (r_cnt < C_MIN);
    w_e_fcs     = w_close && !w_e_align && !w_e_short && (r_crc != C_RES);
    w_good      = w_close && !w_e_align && !w_e_short && !w_e_fcs;
    w_done      = w_close || w_abend || w_long;
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge netclk or negedge reset) begin
    if (!reset) begin
      r_sr         <= '1;
      r_dv         <= '0;
      r_ones       <= '0;
      r_crc        <= '1;
      r_byte       <= '0;
      r_bitcnt     <= '0;
      r_cnt        <= '0;
      r_dly        <= '0;
      r_byte_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_done       <= 1'b0;
      r_dout       <= '0;
      r_good       <= 1'b0;
      r_efcs       <= 1'b0;
      r_eabort     <= 1'b0;
      r_eshort     <= 1'b0;
      r_elong      <= 1'b0;
      r_ealign     <= 1'b0;
      r_len        <= '0;
    end else begin
      r_byte_valid <= w_emit;
      r_sof        <= w_sof;
      r_done       <= w_done;
      if (w_emit) r_dout <= r_dly[7:0];
      // Status is held until the next frame's first byte or the next end.
      if (w_done) begin
        r_good   <= w_good;
        r_efcs   <= w_e_fcs;
        r_eabort <= w_abend;
        r_eshort <= w_e_short;
        r_elong  <= w_long;
        r_ealign <= w_e_align;
        r_len    <= w_len;
      end else if (w_sof) begin
        r_good   <= 1'b0;
        r_efcs   <= 1'b0;
        r_eabort <= 1'b0;
        r_eshort <= 1'b0;
        r_elong  <= 1'b0;
        r_ealign <= 1'b0;
        r_len    <= '0;
      end
      if (w_en) begin
        r_sr   <= w_sr_nx;
        // Flag bits are never data: wipe the marks when a flag completes.
        r_dv   <= w_flag_nx ? 8'h00 : {!w_stuff, r_dv[7:1]};
        r_ones <= w_rx ? ((r_ones == 4'd15) ? 4'd15 : r_ones + 4'd1) : 4'd0;
        if (w_proc) begin
          r_crc    <= w_crc_nx;
          r_byte   <= w_byte_nx;
          r_bitcnt <= w_bitcnt_base + 3'd1;
          r_cnt    <= w_byte_done ? (w_cnt_base + 1'b1) : w_cnt_base;
          if (w_byte_done) r_dly <= {w_byte_nx, r_dly[8*C_FCS_BYTES-1:8]};
        end
      end
    end
  end

  assign rx_if.byte_valid = r_byte_valid;
  assign rx_if.dout       = r_dout;
  assign rx_if.sof        = r_sof;
  assign rx_if.frame_done = r_done;
  assign rx_if.frame_good = r_good;
  assign rx_if.err_fcs    = r_efcs;
  assign rx_if.err_abort  = r_eabort;
  assign rx_if.err_short  = r_eshort;
  assign rx_if.err_long   = r_elong;
  assign rx_if.err_align  = r_ealign;
  assign rx_if.frame_len  = r_len;
  assign rx_if.idle       = (r_ones == 4'd15);
  assign rx_if.rx_active  = (r_state == S_DATA);

endmodule
`default_nettype wire
